// File: rtl/updown_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//
// Shared types and helpers for the up/down modulo counter slice.
//
// Contents:
//   dir_t     - count direction encoding seen on the top-level 'dir' pin
//   ps_width  - bit width needed to hold a prescaler value 0..PRESCALE-1,
//               never less than one bit so a PRESCALE of 1 still has a
//               (constant-zero) register to reason about
// -----------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   // Width of the prescaler phase register for a given prescale ratio.
   function automatic int ps_width(input int prescale);
      int w;
      w = $clog2(prescale);
      if (w < 1) begin
         ps_width = 1;
      end else begin
         ps_width = w;
      end
   endfunction

endpackage : counter_pkg

// File: rtl/updown_mod_counter_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Prescaler for the up/down counter. Produces a clock-enable strobe instead of
// a derived clock so the whole counter stays in one clock domain.
//
// The phase register runs 0..PRESCALE-1 and only advances on enabled cycles.
// 'tick' is decoded combinationally from the phase: it is high while the
// phase sits at PRESCALE-1, and the phase returns to 0 on the enabled cycle
// that consumes that tick. With enable low the phase (and hence tick) freezes.
// For PRESCALE = 1 the phase is permanently 0 and tick is permanently 1.
//
// Parameters:
//   PRESCALE  enabled clocks per tick (>= 1)
//
// Ports:
//   clk     in  1  clock, rising edge
//   reset   in  1  synchronous active-high reset, phase -> 0
//   enable  in  1  advances the phase when high
//   clear   in  1  synchronous phase restart (driven by a parallel load)
//   tick    out 1  terminal-count strobe, combinational from the phase
// -----------------------------------------------------------------------------
module tick_gen
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int              PS_W    = ps_width(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};
   localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

   logic [PS_W-1:0] ps_r;
   logic [PS_W-1:0] ps_next_s;
   logic            tick_s;

   // Terminal-count decode of the current phase.
   always_comb begin
      tick_s = (ps_r == PS_LAST);
   end

   // Next phase: clear beats counting; a frozen phase simply holds.
   always_comb begin
      ps_next_s = ps_r;
      if (clear) begin
         ps_next_s = PS_ZERO;
      end else if (enable) begin
         if (tick_s) begin
            ps_next_s = PS_ZERO;
         end else begin
            ps_next_s = ps_r + PS_ONE;
         end
      end else begin
         ps_next_s = ps_r;
      end
   end

   // Phase register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ps_r <= PS_ZERO;
      end else begin
         ps_r <= ps_next_s;
      end
   end

   assign tick = tick_s;

endmodule : tick_gen

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//
// Parametrised synchronous modulo counter with up/down count, parallel load
// and a one-cycle wrap flag. A built-in prescaler (tick_gen) supplies the
// clock-enable strobe that paces counting, so no derived clocks are needed.
// Intended to sit between board switches/keys and display logic.
//
// Build option:
//   COUNTER_SAT_EN  when defined, counting saturates at the range bounds
//                   (up holds at MODULUS-1, down holds at 0) and 'wrap'
//                   pulses for each step blocked at a bound. When undefined
//                   the counter wraps modulo MODULUS. Load, prescaler and
//                   reset behave identically in both builds.
//
// Parameters:
//   WIDTH     count register width in bits
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   PRESCALE  enabled clocks per count step (>= 1)
//
// Ports:
//   clk         in  1      clock, all state changes on the rising edge
//   reset       in  1      synchronous active-high reset, highest priority
//   enable      in  1      gates prescaler advance and counting
//   dir         in  1      1 = count up, 0 = count down
//   load        in  1      parallel load request (beats counting)
//   load_value  in  WIDTH  value to load, clamped to MODULUS-1
//   count       out WIDTH  current count, registered
//   wrap        out 1      registered one-cycle pulse after a wrapping
//                          (or, saturating build, a blocked) step
//   tick        out 1      prescaler terminal-count strobe, combinational
// -----------------------------------------------------------------------------
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             tick
);

   // Count arithmetic runs one bit wider than the register so that
   // MODULUS-1 and count+1 are representable even when MODULUS == 2**WIDTH.
   localparam int            XW       = WIDTH + 1;
   localparam logic [XW-1:0] MOD_LAST = XW'(MODULUS - 1);
   localparam logic [XW-1:0] X_ZERO   = {XW{1'b0}};
   localparam logic [XW-1:0] X_ONE    = XW'(1);

   // Reject parameter sets that would give a meaningless range.
   generate
      if ((MODULUS < 2) || (MODULUS > (1 << WIDTH)) || (PRESCALE < 1)) begin : g_bad_params
         $error("updown_mod_counter: need 2 <= MODULUS <= 2**WIDTH and PRESCALE >= 1");
      end
   endgenerate

   logic [WIDTH-1:0] count_r;
   logic             wrap_r;
   logic             tick_s;
   logic             step_s;
   dir_t             dir_s;

   logic [XW-1:0]    cur_x_s;
   logic [XW-1:0]    up_x_s;
   logic [XW-1:0]    down_x_s;
   logic [XW-1:0]    load_x_s;
   logic [XW-1:0]    load_clamp_x_s;
   logic [XW-1:0]    next_x_s;
   logic             at_top_s;
   logic             at_bottom_s;
   logic             wrap_next_s;
   logic [WIDTH-1:0] count_next_s;

   // Prescaler; a load restarts its phase so the loaded value is held for a
   // full prescale period before the next step.
   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (load),
      .tick   (tick_s)
   );

   assign dir_s = dir_t'(dir);

   // Step qualification and widened operands for the next-count logic.
   always_comb begin
      step_s      = enable & tick_s & ~load;
      cur_x_s     = {1'b0, count_r};
      up_x_s      = cur_x_s + X_ONE;
      down_x_s    = cur_x_s - X_ONE;
      at_top_s    = (cur_x_s == MOD_LAST);
      at_bottom_s = (cur_x_s == X_ZERO);
      load_x_s    = {1'b0, load_value};
   end

   // Out-of-range load values are pinned to the top of the range.
   always_comb begin
      if (load_x_s > MOD_LAST) begin
         load_clamp_x_s = MOD_LAST;
      end else begin
         load_clamp_x_s = load_x_s;
      end
   end

   // Next count and wrap: load beats step beats hold.
   always_comb begin
      next_x_s    = cur_x_s;
      wrap_next_s = 1'b0;
      if (load) begin
         next_x_s    = load_clamp_x_s;
         wrap_next_s = 1'b0;
      end else if (step_s) begin
         case (dir_s)
            DIR_UP: begin
               if (at_top_s) begin
`ifdef COUNTER_SAT_EN
                  next_x_s = cur_x_s;
`else
                  next_x_s = X_ZERO;
`endif
                  wrap_next_s = 1'b1;
               end else begin
                  next_x_s    = up_x_s;
                  wrap_next_s = 1'b0;
               end
            end
            DIR_DOWN: begin
               if (at_bottom_s) begin
`ifdef COUNTER_SAT_EN
                  next_x_s = cur_x_s;
`else
                  next_x_s = MOD_LAST;
`endif
                  wrap_next_s = 1'b1;
               end else begin
                  next_x_s    = down_x_s;
                  wrap_next_s = 1'b0;
               end
            end
            default: begin
               next_x_s    = cur_x_s;
               wrap_next_s = 1'b0;
            end
         endcase
      end else begin
         next_x_s    = cur_x_s;
         wrap_next_s = 1'b0;
      end
   end

   // Defensive range guard: a next value outside 0..MODULUS-1 cannot arise
   // from the logic above, but if it ever did the counter recovers to 0.
   always_comb begin
      if (next_x_s > MOD_LAST) begin
         count_next_s = {WIDTH{1'b0}};
      end else begin
         count_next_s = next_x_s[WIDTH-1:0];
      end
   end

   // Count and wrap registers; reset wins over any load or step in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {WIDTH{1'b0}};
         wrap_r  <= 1'b0;
      end else begin
         count_r <= count_next_s;
         wrap_r  <= wrap_next_s;
      end
   end

   assign count = count_r;
   assign wrap  = wrap_r;
   assign tick  = tick_s;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter
//
// Three counters share one set of inputs:
//   A: WIDTH=4 MODULUS=10 PRESCALE=1
//   B: WIDTH=4 MODULUS=10 PRESCALE=4
//   C: WIDTH=4 MODULUS=16 PRESCALE=3  (MODULUS == 2**WIDTH)
// A stimulus table with hand-derived expectations exercises A, short
// hand-written sequences cover the prescaler and load-on-tick cases on B and
// the full-range case on C, and a random phase runs all three against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_updown_mod_counter;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       dir;
   logic       load;
   logic [3:0] load_value;

   logic [3:0] cnt_a, cnt_b, cnt_c;
   logic       wrap_a, wrap_b, wrap_c;
   logic       tick_a, tick_b, tick_c;

   int total = 0;
   int bad   = 0;

   // Reference model state, one slot per instance.
   int mod_p[NI] = '{10, 10, 16};
   int pre_p[NI] = '{1, 4, 3};
   int mc[NI];
   int mp[NI];
   int mw[NI];

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .load_value(load_value), .count(cnt_a), .wrap(wrap_a), .tick(tick_a));

   updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .load_value(load_value), .count(cnt_b), .wrap(wrap_b), .tick(tick_b));

   updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) dut_c (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .load_value(load_value), .count(cnt_c), .wrap(wrap_c), .tick(tick_c));

   // Advance the model by one clock given this cycle's inputs.
   function automatic void model_step(input bit r, input bit e, input bit d,
                                      input bit l, input int lv);
      for (int i = 0; i < NI; i++) begin
         if (r) begin
            mc[i] = 0; mp[i] = 0; mw[i] = 0;
         end else if (l) begin
            mc[i] = (lv >= mod_p[i]) ? mod_p[i] - 1 : lv;
            mp[i] = 0; mw[i] = 0;
         end else begin
            mw[i] = 0;
            if (e) begin
               if (mp[i] == pre_p[i] - 1) begin
                  mp[i] = 0;
                  if (d) begin
                     if (mc[i] == mod_p[i] - 1) begin
                        mw[i] = 1;
`ifndef COUNTER_SAT_EN
                        mc[i] = 0;
`endif
                     end else begin
                        mc[i] = mc[i] + 1;
                     end
                  end else begin
                     if (mc[i] == 0) begin
                        mw[i] = 1;
`ifndef COUNTER_SAT_EN
                        mc[i] = mod_p[i] - 1;
`endif
                     end else begin
                        mc[i] = mc[i] - 1;
                     end
                  end
               end else begin
                  mp[i] = mp[i] + 1;
               end
            end
         end
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_models();
      check("A.count", {28'd0, cnt_a}, mc[0]);
      check("A.wrap",  {31'd0, wrap_a}, mw[0]);
      check("A.tick",  {31'd0, tick_a}, (mp[0] == pre_p[0] - 1) ? 1 : 0);
      check("B.count", {28'd0, cnt_b}, mc[1]);
      check("B.wrap",  {31'd0, wrap_b}, mw[1]);
      check("B.tick",  {31'd0, tick_b}, (mp[1] == pre_p[1] - 1) ? 1 : 0);
      check("C.count", {28'd0, cnt_c}, mc[2]);
      check("C.wrap",  {31'd0, wrap_c}, mw[2]);
      check("C.tick",  {31'd0, tick_c}, (mp[2] == pre_p[2] - 1) ? 1 : 0);
   endtask

   // Drive one cycle of inputs at the falling edge, clock it, sample at the
   // next falling edge and compare everything against the model.
   task automatic cyc(input bit r, input bit e, input bit d, input bit l, input int lv);
      logic [31:0] lvv;
      lvv        = lv;
      reset      = r;
      enable     = e;
      dir        = d;
      load       = l;
      load_value = lvv[3:0];
      model_step(r, e, d, l, lv);
      @(posedge clk);
      @(negedge clk);
      check_models();
   endtask

   typedef struct {
      bit r; bit e; bit d; bit l;
      int lv;
      int ec;
      bit ew;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit r, input bit e, input bit d, input bit l,
                               input int lv, input int ec, input bit ew);
      vec_t v;
      v.r = r; v.e = e; v.d = d; v.l = l; v.lv = lv; v.ec = ec; v.ew = ew;
      return v;
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b0; dir = 1'b1; load = 1'b0; load_value = 4'd0;
      for (int i = 0; i < NI; i++) begin
         mc[i] = 0; mp[i] = 0; mw[i] = 0;
      end
      @(negedge clk);

      // ---- table for instance A (MODULUS 10, PRESCALE 1) ----
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
`ifndef COUNTER_SAT_EN
      for (int k = 1; k <= 9; k++) tbl.push_back(mk(0, 1, 1, 0, 0, k, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 2, 0));
      tbl.push_back(mk(0, 1, 0, 1, 2, 2, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 9, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 1, 13, 9, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
`else
      tbl.push_back(mk(0, 1, 1, 1, 8, 8, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 9, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 9, 1));
      tbl.push_back(mk(0, 1, 1, 1, 13, 9, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
`endif
      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].l, tbl[i].lv);
         check($sformatf("tbl%0d.A.count", i), {28'd0, cnt_a}, tbl[i].ec);
         check($sformatf("tbl%0d.A.wrap", i),  {31'd0, wrap_a}, tbl[i].ew);
         check($sformatf("tbl%0d.A.tick", i),  {31'd0, tick_a}, 1);
      end

      // ---- prescaler on B: 12 enabled clocks give exactly 3 steps ----
      cyc(1, 1, 1, 0, 0);
      check("B.reset.tick", {31'd0, tick_b}, 0);
      for (int k = 0; k < 12; k++) cyc(0, 1, 1, 0, 0);
      check("B.after12.count", {28'd0, cnt_b}, 3);
      check("B.after12.tick",  {31'd0, tick_b}, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 0);
      check("B.preTick.tick", {31'd0, tick_b}, 1);
      // enable low: count and tick frozen
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 1, 0, 0);
         check("B.frozen.count", {28'd0, cnt_b}, 3);
         check("B.frozen.tick",  {31'd0, tick_b}, 1);
      end
      // load on a tick cycle: loaded value wins, prescaler restarts
      cyc(0, 1, 1, 1, 5);
      check("B.loadTick.count", {28'd0, cnt_b}, 5);
      check("B.loadTick.tick",  {31'd0, tick_b}, 0);
      check("B.loadTick.wrap",  {31'd0, wrap_b}, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 0);
      check("B.afterLoad3.count", {28'd0, cnt_b}, 5);
      cyc(0, 1, 1, 0, 0);
      check("B.afterLoad4.count", {28'd0, cnt_b}, 6);

      // ---- full-range C: down from 0 at MODULUS == 2**WIDTH ----
      cyc(1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);
`ifndef COUNTER_SAT_EN
      check("C.downWrap.count", {28'd0, cnt_c}, 15);
`else
      check("C.downWrap.count", {28'd0, cnt_c}, 0);
`endif
      check("C.downWrap.wrap", {31'd0, wrap_c}, 1);
      cyc(0, 1, 1, 1, 15);
      check("C.load15.count", {28'd0, cnt_c}, 15);
      check("A.load15.count", {28'd0, cnt_a}, 9);

      // ---- reset mid-load: reset wins ----
      cyc(1, 1, 1, 1, 7);
      check("A.resetLoad.count", {28'd0, cnt_a}, 0);

      // ---- random phase against the model ----
      for (int n = 0; n < 800; n++) begin
         cyc(($urandom_range(0, 49) == 0),
             ($urandom_range(0, 3) != 0),
             $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0),
             $urandom_range(0, 15));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_updown_mod_counter
